// File: rtl/bambu_mem_pkg.sv
// Shared definitions for the Bambu external-memory responder: access-size
// encodings, default latencies, the per-channel request record and the
// size decode helper.
package bambu_mem_pkg;

  // Access size field carries the width in bits.
  localparam logic [6:0] SZ_8  = 7'd8;
  localparam logic [6:0] SZ_16 = 7'd16;
  localparam logic [6:0] SZ_32 = 7'd32;
  localparam logic [6:0] SZ_64 = 7'd64;

  localparam int DEFAULT_READ_DELAY  = 2;
  localparam int DEFAULT_WRITE_DELAY = 1;

  // Request fields are held at their widest supported widths; channel
  // inputs are zero-extended into them.
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 64;
  localparam int REQ_SIZE_W = 7;

  typedef struct packed {
    logic                  oe;
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_SIZE_W-1:0] size;
  } mem_req_t;

  // Number of bytes touched by an access; 0 marks an illegal size.
  function automatic logic [3:0] size_to_bytes(input logic [REQ_SIZE_W-1:0] size);
    case (size)
      SZ_8:    return 4'd1;
      SZ_16:   return 4'd2;
      SZ_32:   return 4'd4;
      SZ_64:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/bambu_slave_delay_line.sv
// Fixed-latency shift pipeline of {valid, data}. The output appears DEPTH
// cycles after the input is sampled. Reset flushes every stage so nothing
// in flight survives it.
module bambu_slave_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  // Shift valid and payload one stage per cycle; reset clears all stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/bambu_slave_mem_responder.sv
// Responder side of the Bambu external-memory port. Serves a byte-addressed
// RAM window to CHANNELS independent ports with fixed read/write latencies.
// Optional build macro: BAMBU_SLAVE_MEM_CHECK_EN adds a sticky err_o output
// flagging illegal sizes, window-crossing accesses and oe&we on one channel.
//
// Request/completion semantics: S_oe_ram[c] / S_we_ram[c] are single-cycle
// request strobes, sampled on the rising clock edge together with address,
// data and size. There is no ready: a request that hits the window is always
// accepted. Each accepted request produces exactly one Sout_DataRdy[c] pulse
// READ_DELAY (read) or WRITE_DELAY (write) cycles later, in issue order, and
// Sout_Rdata_ram is meaningful only while that pulse is high (0 otherwise).
// A read and a write completing in the same cycle on one channel share a
// single pulse. Misses produce nothing and drive zeros, so responders on
// the shared bus can be OR-combined.
module bambu_slave_mem_responder
  import bambu_mem_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 64,
  parameter int SIZE_W      = 7,
  parameter int BASE_ADDR   = 0,
  parameter int MEM_BYTES   = 64,
  parameter int READ_DELAY  = DEFAULT_READ_DELAY,
  parameter int WRITE_DELAY = DEFAULT_WRITE_DELAY
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          S_oe_ram,
  input  logic [CHANNELS-1:0]          S_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   S_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   S_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   S_data_ram_size,
  output logic [CHANNELS*DATA_W-1:0]   Sout_Rdata_ram,
  output logic [CHANNELS-1:0]          Sout_DataRdy
`ifdef BAMBU_SLAVE_MEM_CHECK_EN
  ,
  output logic                         err_o
`endif
);

  localparam int MEM_AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  // Byte RAM; contents deliberately survive reset.
  logic [7:0] mem [MEM_BYTES];

  mem_req_t              req       [CHANNELS];
  logic [REQ_ADDR_W-1:0] win_off   [CHANNELS];
  logic [3:0]            nbytes    [CHANNELS];
  logic [CHANNELS-1:0]   hit;
  logic [CHANNELS-1:0]   rd_fire;
  logic [CHANNELS-1:0]   wr_fire;
  logic [REQ_ADDR_W-1:0] lane_addr [CHANNELS][8];
  logic [7:0]            byte_ok   [CHANNELS];
  logic [MEM_AW-1:0]     byte_idx  [CHANNELS][8];
  logic [REQ_DATA_W-1:0] rd_bytes  [CHANNELS];

  logic [CHANNELS-1:0]   rd_v;
  logic [CHANNELS-1:0]   wr_v;
  logic [DATA_W-1:0]     rd_d      [CHANNELS];
  logic [DATA_W-1:0]     wr_d      [CHANNELS];

  // Decode each channel: hit test, byte lanes inside the window, and the
  // read data as seen before this edge's writes land (old value on collision).
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      req[c].oe    = S_oe_ram[c];
      req[c].we    = S_we_ram[c];
      req[c].addr  = REQ_ADDR_W'(S_addr_ram[c*ADDR_W +: ADDR_W]);
      req[c].wdata = REQ_DATA_W'(S_Wdata_ram[c*DATA_W +: DATA_W]);
      req[c].size  = REQ_SIZE_W'(S_data_ram_size[c*SIZE_W +: SIZE_W]);

      // Addresses below the base wrap to a huge offset and miss.
      win_off[c] = req[c].addr - REQ_ADDR_W'(BASE_ADDR);
      hit[c]     = win_off[c] < REQ_ADDR_W'(MEM_BYTES);
      nbytes[c]  = size_to_bytes(req[c].size);
      wr_fire[c] = req[c].we & hit[c];
      rd_fire[c] = req[c].oe & ~req[c].we & hit[c];

      rd_bytes[c] = '0;
      byte_ok[c]  = '0;
      for (int i = 0; i < 8; i++) begin
        lane_addr[c][i] = win_off[c] + REQ_ADDR_W'(i);
        byte_ok[c][i]   = (4'(i) < nbytes[c]) &&
                          (lane_addr[c][i] < REQ_ADDR_W'(MEM_BYTES));
        byte_idx[c][i]  = lane_addr[c][i][MEM_AW-1:0];
        rd_bytes[c][8*i +: 8] = (rd_fire[c] && byte_ok[c][i]) ?
                                mem[byte_idx[c][i]] : 8'h00;
      end
    end
  end

  // Commit write bytes at the request edge; later channels override earlier
  // ones on the same byte, so the highest channel index wins.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_fire[c] && byte_ok[c][i]) begin
          mem[byte_idx[c][i]] <= req[c].wdata[8*i +: 8];
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    bambu_slave_delay_line #(
      .DEPTH (READ_DELAY),
      .W     (DATA_W)
    ) u_rd_line (
      .clock   (clock),
      .reset   (reset),
      .valid_i (rd_fire[c]),
      .data_i  (rd_bytes[c][DATA_W-1:0]),
      .valid_o (rd_v[c]),
      .data_o  (rd_d[c])
    );

    // Write completions carry a zero payload so both lines merge alike.
    bambu_slave_delay_line #(
      .DEPTH (WRITE_DELAY),
      .W     (DATA_W)
    ) u_wr_line (
      .clock   (clock),
      .reset   (reset),
      .valid_i (wr_fire[c]),
      .data_i  ('0),
      .valid_o (wr_v[c]),
      .data_o  (wr_d[c])
    );

    assign Sout_DataRdy[c]                      = rd_v[c] | wr_v[c];
    assign Sout_Rdata_ram[c*DATA_W +: DATA_W]   = rd_d[c] | wr_d[c];
  end

`ifdef BAMBU_SLAVE_MEM_CHECK_EN
  logic [CHANNELS-1:0] err_hit;

  // Flag protocol misuse on accepted requests.
  always_comb begin
    err_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      err_hit[c] = hit[c] && (req[c].oe || req[c].we) &&
                   ((nbytes[c] == 4'd0) ||
                    ((win_off[c] + REQ_ADDR_W'(nbytes[c])) > REQ_ADDR_W'(MEM_BYTES)) ||
                    (req[c].oe && req[c].we));
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_o <= 1'b0;
    end else if (|err_hit) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bambu_slave_mem_responder.sv
// Directed bench for bambu_slave_mem_responder (default parameters).
module tb_bambu_slave_mem_responder;

  localparam int CH = 2;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int SW = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     S_oe_ram;
  logic [CH-1:0]     S_we_ram;
  logic [CH*AW-1:0]  S_addr_ram;
  logic [CH*DW-1:0]  S_Wdata_ram;
  logic [CH*SW-1:0]  S_data_ram_size;
  logic [CH*DW-1:0]  Sout_Rdata_ram;
  logic [CH-1:0]     Sout_DataRdy;
`ifdef BAMBU_SLAVE_MEM_CHECK_EN
  logic              err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] exp_q[$];
  int            issue_q[$];

  bambu_slave_mem_responder dut (
    .clock           (clock),
    .reset           (reset),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
`ifdef BAMBU_SLAVE_MEM_CHECK_EN
    ,
    .err_o           (err_o)
`endif
  );

  // Clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clr();
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
  endtask

  task automatic rd(input int ch, input logic [AW-1:0] a, input logic [SW-1:0] sz);
    S_oe_ram[ch]                 = 1'b1;
    S_we_ram[ch]                 = 1'b0;
    S_addr_ram[ch*AW +: AW]      = a;
    S_data_ram_size[ch*SW +: SW] = sz;
  endtask

  task automatic wr(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [SW-1:0] sz);
    S_oe_ram[ch]                 = 1'b0;
    S_we_ram[ch]                 = 1'b1;
    S_addr_ram[ch*AW +: AW]      = a;
    S_Wdata_ram[ch*DW +: DW]     = d;
    S_data_ram_size[ch*SW +: SW] = sz;
  endtask

  function automatic logic [DW-1:0] rdata(input int ch);
    return Sout_Rdata_ram[ch*DW +: DW];
  endfunction

  task automatic chk64(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic [CH-1:0] exp);
    n_checks++;
    assert (Sout_DataRdy === exp) else begin
      n_fail++;
      $error("FAIL %s: observed DataRdy %b expected %b", tag, Sout_DataRdy, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

`ifdef BAMBU_SLAVE_MEM_CHECK_EN
  task automatic chk_err(input string tag, input logic exp);
    n_checks++;
    assert (err_o === exp) else begin
      n_fail++;
      $error("FAIL %s: observed err_o %b expected %b", tag, err_o, exp);
    end
  endtask
`endif

  initial begin
    logic [7:0]    b;
    logic [DW-1:0] e;
    int            iss;
    int            pulses;

    // Reset state
    clr();
    reset = 1'b1;
    tick();
    tick();
    chk_rdy("reset_rdy", 2'b00);
    chk64("reset_rdata0", rdata(0), 64'h0);
    chk64("reset_rdata1", rdata(1), 64'h0);
    reset = 1'b0;
    tick();
`ifdef BAMBU_SLAVE_MEM_CHECK_EN
    chk_err("err_after_reset", 1'b0);
`endif

    // Zero the whole window with back-to-back 64-bit writes
    for (int k = 0; k < 8; k++) begin
      clr();
      wr(0, 8'(8*k), 64'h0, 7'd64);
      tick();
      chk_rdy("fill_wr_rdy", 2'b01);
    end
    clr();
    tick();

    // Single write then read
    clr(); wr(0, 8'h08, 64'h11223344, 7'd32); tick();
    chk_rdy("wr32_rdy", 2'b01);
    chk64("wr32_rdata_zero", rdata(0), 64'h0);
    clr(); rd(0, 8'h08, 7'd32); tick();
    chk_rdy("rd32_not_yet", 2'b00);
    clr(); tick();
    chk_rdy("rd32_rdy", 2'b01);
    chk64("rd32_data", rdata(0), 64'h11223344);
    tick();
    chk_rdy("rd32_pulse_end", 2'b00);
    chk64("rd32_rdata_idle", rdata(0), 64'h0);

    // Sub-word write, little-endian 64-bit read back
    clr(); wr(0, 8'h09, 64'hAB, 7'd8); tick();
    chk_rdy("wr8_rdy", 2'b01);
    clr(); rd(0, 8'h08, 7'd64); tick();
    clr(); tick();
    chk64("subword_le", rdata(0), 64'h0000_0000_1122_AB44);

    // Dual channel same-cycle writes, then read/write collision
    clr(); wr(0, 8'h10, 64'h55, 7'd8); wr(1, 8'h10, 64'h66, 7'd8); tick();
    chk_rdy("dual_wr_rdy", 2'b11);
    clr(); rd(0, 8'h10, 7'd8); wr(1, 8'h10, 64'h77, 7'd8); tick();
    chk_rdy("rw_collide_wr_rdy", 2'b10);
    clr(); rd(0, 8'h10, 7'd8); rd(1, 8'h10, 7'd8); tick();
    chk_rdy("rw_collide_rd_rdy", 2'b01);
    chk64("dual_wr_high_wins_old_read", rdata(0), 64'h66);
    clr(); tick();
    chk_rdy("after_collide_rdy", 2'b11);
    chk64("after_collide_rd0", rdata(0), 64'h77);
    chk64("after_collide_rd1", rdata(1), 64'h77);

    // Pattern fill: 8 bytes of 0x20+k at 8*k
    for (int k = 0; k < 8; k++) begin
      b = 8'h20 + 8'(k);
      clr(); wr(0, 8'(8*k), {8{b}}, 7'd64); tick();
    end
    clr();
    tick();

    // Back-to-back reads on ch1 for 8 cycles
    pulses = 0;
    for (int k = 0; k < 11; k++) begin
      if (Sout_DataRdy[1]) begin
        pulses++;
        if (exp_q.size() == 0) begin
          chk_int("burst_extra_pulse", int'(Sout_DataRdy[1]), 0);
        end else begin
          e   = exp_q.pop_front();
          iss = issue_q.pop_front();
          chk64("burst_data", rdata(1), e);
          chk_int("burst_latency", cyc - iss, 2);
        end
      end
      clr();
      if (k < 8) begin
        rd(1, 8'(8*k), 7'd64);
        b = 8'h20 + 8'(k);
        exp_q.push_back({8{b}});
        issue_q.push_back(cyc);
      end
      tick();
    end
    chk_int("burst_count", pulses, 8);
    chk_int("burst_drained", exp_q.size(), 0);

    // Miss: no completion, no aliasing into the window
    clr(); rd(0, 8'h40, 7'd8); wr(1, 8'h40, 64'hFF, 7'd8); tick();
    chk_rdy("miss_rdy_d1", 2'b00);
    clr(); tick();
    chk_rdy("miss_rdy_d2", 2'b00);
    chk64("miss_rdata", rdata(0), 64'h0);
    clr(); rd(0, 8'h00, 7'd8); tick();
    clr(); tick();
    chk64("miss_no_alias", rdata(0), 64'h20);
`ifdef BAMBU_SLAVE_MEM_CHECK_EN
    chk_err("err_clean_before_cross", 1'b0);
`endif

    // Window-crossing read and write
    clr(); rd(0, 8'h3E, 7'd32); tick();
    clr(); tick();
    chk_rdy("cross_rd_rdy", 2'b01);
    chk64("cross_rd_data", rdata(0), 64'h2727);
`ifdef BAMBU_SLAVE_MEM_CHECK_EN
    chk_err("err_cross", 1'b1);
`endif
    clr(); wr(1, 8'h3E, 64'hDDCCBBAA, 7'd32); tick();
    chk_rdy("cross_wr_rdy", 2'b10);
    clr(); rd(1, 8'h3C, 7'd32); tick();
    clr(); tick();
    chk64("cross_wr_data", rdata(1), 64'hBBAA2727);

    // Illegal sizes
    clr(); wr(0, 8'h00, 64'hFFFFFF, 7'd24); tick();
    chk_rdy("illegal_wr_rdy", 2'b01);
    clr(); rd(0, 8'h00, 7'd12); tick();
    clr(); tick();
    chk_rdy("illegal_rd_rdy", 2'b01);
    chk64("illegal_rd_data", rdata(0), 64'h0);
    clr(); rd(0, 8'h00, 7'd64); tick();
    clr(); tick();
    chk64("illegal_wr_no_effect", rdata(0), 64'h2020202020202020);

    // oe and we together: write executes, read dropped
    clr(); wr(0, 8'h01, 64'h99, 7'd8); S_oe_ram[0] = 1'b1; tick();
    chk_rdy("oewe_wr_rdy", 2'b01);
    clr(); tick();
    chk_rdy("oewe_no_read", 2'b00);
    clr(); rd(0, 8'h00, 7'd16); tick();
    clr(); tick();
    chk64("oewe_write_done", rdata(0), 64'h9920);

    // Reset with reads in flight
    clr(); rd(0, 8'h08, 7'd32); tick();
    clr(); rd(0, 8'h10, 7'd32); tick();
    clr();
    chk_rdy("pre_reset_rdy", 2'b01);
    chk64("pre_reset_data", rdata(0), 64'h21212121);
    reset = 1'b1;
    #1;
    chk_rdy("reset_async_rdy", 2'b00);
    chk64("reset_async_rdata", rdata(0), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_rdy("post_reset_rdy_1", 2'b00);
    tick();
    chk_rdy("post_reset_rdy_2", 2'b00);
`ifdef BAMBU_SLAVE_MEM_CHECK_EN
    chk_err("err_cleared_by_reset", 1'b0);
`endif
    clr(); rd(0, 8'h08, 7'd32); tick();
    clr(); tick();
    chk_rdy("ram_retained_rdy", 2'b01);
    chk64("ram_retained", rdata(0), 64'h21212121);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
